// File: rtl/cam_i2c_target.sv
// I2C target engine modelling a camera sensor control port: 7-bit device address,
// 16-bit auto-incrementing register pointer, 8-bit data, single-cycle register strobes.
module cam_i2c_target #(
   parameter logic [6:0]  DEV_ADDR = 7'h36,
   parameter int unsigned FILTER   = 3
) (
   input  logic        sys_clk,
   input  logic        reset,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        sda_oe,
   output logic [15:0] reg_addr,
   output logic [7:0]  reg_wdata,
   output logic        reg_we,
   output logic        reg_rd,
   input  logic [7:0]  reg_rdata,
   output logic        bus_active,
   output logic        selected
);

   localparam logic [3:0] ST_IDLE       = 4'd0;
   localparam logic [3:0] ST_DEVADDR    = 4'd1;
   localparam logic [3:0] ST_ACK_DEV_W  = 4'd2;
   localparam logic [3:0] ST_ACK_DEV_R  = 4'd3;
   localparam logic [3:0] ST_PTR_HI     = 4'd4;
   localparam logic [3:0] ST_PTR_LO     = 4'd5;
   localparam logic [3:0] ST_WRITE_BYTE = 4'd6;
   localparam logic [3:0] ST_READ_BYTE  = 4'd7;
   localparam logic [3:0] ST_IGNORE     = 4'd8;

   // Index 0 = SCL, index 1 = SDA through synchronizer and stability filter.
   logic [1:0] sync1_q, sync2_q, filt_q, filt_prev_q;
   logic [3:0] fcnt_q [2];

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         sync1_q     <= '1;
         sync2_q     <= '1;
         filt_q      <= '1;
         filt_prev_q <= '1;
         fcnt_q[0]   <= '0;
         fcnt_q[1]   <= '0;
      end else begin
         sync1_q     <= {sda_in, scl_in};
         sync2_q     <= sync1_q;
         filt_prev_q <= filt_q;
         for (int unsigned i = 0; i < 2; i++) begin
            if (sync2_q[i] == filt_q[i]) begin
               fcnt_q[i] <= '0;
            end else if (fcnt_q[i] == 4'(FILTER - 1)) begin
               filt_q[i] <= sync2_q[i];
               fcnt_q[i] <= '0;
            end else begin
               fcnt_q[i] <= fcnt_q[i] + 4'd1;
            end
         end
      end
   end

   logic scl_f, sda_f, scl_rise, scl_fall, start_ev, stop_ev;
   assign scl_f    = filt_q[0];
   assign sda_f    = filt_q[1];
   assign scl_rise = scl_f & ~filt_prev_q[0];
   assign scl_fall = ~scl_f & filt_prev_q[0];
   assign start_ev = ~sda_f & filt_prev_q[1] & scl_f;
   assign stop_ev  = sda_f & ~filt_prev_q[1] & scl_f;

   logic [3:0]  state_q, state_d, bit_cnt_q, bit_cnt_d;
   logic        ack_q, ack_d, sda_oe_q, sda_oe_d, reg_we_q, reg_we_d, reg_rd_q, reg_rd_d;
   logic        rd_pend_q, rd_pend_d, bus_active_q, bus_active_d, selected_q, selected_d;
   logic [7:0]  shift_q, shift_d, wdata_q, wdata_d, rdata_q, rdata_d, byte_in;
   logic [15:0] ptr_q, ptr_d;

   assign byte_in = {shift_q[6:0], sda_f};

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      ack_d        = ack_q;
      shift_d      = shift_q;
      ptr_d        = ptr_q;
      sda_oe_d     = sda_oe_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      bus_active_d = bus_active_q;
      selected_d   = selected_q;
      reg_we_d     = 1'b0;
      reg_rd_d     = 1'b0;
      rd_pend_d    = reg_rd_q;
      if (rd_pend_q) rdata_d = reg_rdata;
      if (reg_we_q)  ptr_d = ptr_q + 16'd1;

      if (stop_ev) begin
         state_d      = ST_IDLE;
         sda_oe_d     = 1'b0;
         bus_active_d = 1'b0;
         selected_d   = 1'b0;
      end else if (start_ev) begin
         state_d      = ST_DEVADDR;
         bit_cnt_d    = '0;
         ack_d        = 1'b0;
         bus_active_d = 1'b1;
         selected_d   = 1'b0;
      end else begin
         case (state_q)
            ST_DEVADDR: begin
               if (scl_rise) begin
                  shift_d   = byte_in;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     ack_d = 1'b0;
                     if (shift_q[6:0] != DEV_ADDR) begin
                        state_d = ST_IGNORE;
                     end else if (sda_f) begin
                        state_d  = ST_ACK_DEV_R;
                        reg_rd_d = 1'b1;
                     end else begin
                        state_d = ST_ACK_DEV_W;
                     end
                  end
               end
            end
            ST_ACK_DEV_W, ST_ACK_DEV_R: begin
               if (scl_fall) begin
                  if (!ack_q) begin
                     ack_d      = 1'b1;
                     sda_oe_d   = 1'b1;
                     selected_d = 1'b1;
                  end else begin
                     ack_d     = 1'b0;
                     bit_cnt_d = '0;
                     if (state_q == ST_ACK_DEV_W) begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_PTR_HI;
                     end else begin
                        shift_d  = rdata_q;
                        sda_oe_d = ~rdata_q[7];
                        state_d  = ST_READ_BYTE;
                     end
                  end
               end
            end
            ST_PTR_HI, ST_PTR_LO, ST_WRITE_BYTE: begin
               if (bit_cnt_q != 4'd8) begin
                  if (scl_rise) begin
                     shift_d   = byte_in;
                     bit_cnt_d = bit_cnt_q + 4'd1;
                     if (bit_cnt_q == 4'd7 && state_q == ST_PTR_HI) ptr_d[15:8] = byte_in;
                     if (bit_cnt_q == 4'd7 && state_q == ST_PTR_LO) ptr_d[7:0]  = byte_in;
                  end
               end else if (scl_fall) begin
                  if (!ack_q) begin
                     ack_d    = 1'b1;
                     sda_oe_d = 1'b1;
                     if (state_q == ST_WRITE_BYTE) begin
                        reg_we_d = 1'b1;
                        wdata_d  = shift_q;
                     end
                  end else begin
                     ack_d     = 1'b0;
                     sda_oe_d  = 1'b0;
                     bit_cnt_d = '0;
                     state_d   = (state_q == ST_PTR_HI) ? ST_PTR_LO : ST_WRITE_BYTE;
                  end
               end
            end
            ST_READ_BYTE: begin
               // bit_cnt 8 = awaiting initiator ACK clock, 9 = ACKed, reload on next fall
               if (scl_rise) begin
                  if (bit_cnt_q < 4'd8) begin
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end else if (bit_cnt_q == 4'd8) begin
                     if (!sda_f) begin
                        ptr_d     = ptr_q + 16'd1;
                        reg_rd_d  = 1'b1;
                        bit_cnt_d = 4'd9;
                     end else begin
                        state_d = ST_IGNORE;
                     end
                  end
               end else if (scl_fall) begin
                  if (bit_cnt_q < 4'd8) begin
                     shift_d  = {shift_q[6:0], 1'b0};
                     sda_oe_d = ~shift_q[6];
                  end else if (bit_cnt_q == 4'd8) begin
                     sda_oe_d = 1'b0;
                  end else begin
                     shift_d   = rdata_q;
                     sda_oe_d  = ~rdata_q[7];
                     bit_cnt_d = '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         bit_cnt_q    <= '0;
         ack_q        <= 1'b0;
         shift_q      <= '0;
         ptr_q        <= '0;
         sda_oe_q     <= 1'b0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         reg_we_q     <= 1'b0;
         reg_rd_q     <= 1'b0;
         rd_pend_q    <= 1'b0;
         bus_active_q <= 1'b0;
         selected_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         ack_q        <= ack_d;
         shift_q      <= shift_d;
         ptr_q        <= ptr_d;
         sda_oe_q     <= sda_oe_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         reg_we_q     <= reg_we_d;
         reg_rd_q     <= reg_rd_d;
         rd_pend_q    <= rd_pend_d;
         bus_active_q <= bus_active_d;
         selected_q   <= selected_d;
      end
   end

   assign sda_oe     = sda_oe_q;
   assign reg_addr   = ptr_q;
   assign reg_wdata  = wdata_q;
   assign reg_we     = reg_we_q;
   assign reg_rd     = reg_rd_q;
   assign bus_active = bus_active_q;
   assign selected   = selected_q;

endmodule

// File: tb/tb_cam_i2c_target.sv
// Directed bench for cam_i2c_target: bit-level I2C initiator, open-drain SDA,
// strobe logger and a small register-storage model.
module tb_cam_i2c_target;

   localparam int T = 16;

   logic        sys_clk = 1'b0;
   logic        reset;
   logic        scl_m, sda_m;
   logic        sda_pin;
   logic        sda_oe;
   logic [15:0] reg_addr;
   logic [7:0]  reg_wdata;
   logic        reg_we, reg_rd;
   logic [7:0]  reg_rdata = 8'h00;
   logic        bus_active, selected;

   int checks   = 0;
   int failures = 0;

   assign sda_pin = sda_m & ~sda_oe;

   always #5 sys_clk = ~sys_clk;

   cam_i2c_target #(.DEV_ADDR(7'h36), .FILTER(3)) dut (
      .sys_clk    (sys_clk),
      .reset      (reset),
      .scl_in     (scl_m),
      .sda_in     (sda_pin),
      .sda_oe     (sda_oe),
      .reg_addr   (reg_addr),
      .reg_wdata  (reg_wdata),
      .reg_we     (reg_we),
      .reg_rd     (reg_rd),
      .reg_rdata  (reg_rdata),
      .bus_active (bus_active),
      .selected   (selected)
   );

   // Storage: data appears the cycle after the read strobe.
   always @(posedge sys_clk) begin
      if (reg_rd) begin
         case (reg_addr)
            16'h300A: reg_rdata <= 8'h56;
            16'h300B: reg_rdata <= 8'h47;
            default:  reg_rdata <= 8'hA5;
         endcase
      end
   end

   logic [15:0] we_addr [16];
   logic [7:0]  we_data [16];
   logic [15:0] rd_addr [16];
   int we_n = 0, rd_n = 0, oe_hi_n = 0, sel_n = 0, oe_viol = 0;
   logic oe_prev = 1'b0;

   always @(negedge sys_clk) begin
      if (!reset) begin
         if (reg_we) begin
            if (we_n < 16) begin
               we_addr[we_n] <= reg_addr;
               we_data[we_n] <= reg_wdata;
            end
            we_n <= we_n + 1;
         end
         if (reg_rd) begin
            if (rd_n < 16) rd_addr[rd_n] <= reg_addr;
            rd_n <= rd_n + 1;
         end
         if (sda_oe)   oe_hi_n <= oe_hi_n + 1;
         if (selected) sel_n   <= sel_n + 1;
         if (scl_m && (sda_oe !== oe_prev)) oe_viol <= oe_viol + 1;
         oe_prev <= sda_oe;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic bit_xfer(input logic b, output logic r);
      sda_m = b;
      tick(T);
      scl_m = 1'b1;
      tick(T);
      r = sda_pin;
      tick(T);
      scl_m = 1'b0;
      tick(4);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1;
      tick(T);
      scl_m = 1'b1;
      tick(T);
      sda_m = 1'b0;
      tick(T);
      scl_m = 1'b0;
      tick(4);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0;
      tick(T);
      scl_m = 1'b1;
      tick(T);
      sda_m = 1'b1;
      tick(T);
   endtask

   task automatic wr_byte(input logic [7:0] b, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
      bit_xfer(1'b1, ack);
   endtask

   task automatic rd_byte(input logic nack, output logic [7:0] d);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1, r);
         d[i] = r;
      end
      bit_xfer(nack, r);
   endtask

   logic [5:0] a;
   logic       a0;
   logic [7:0] d0, d1;
   int         snap_we, snap_rd, snap_oe, snap_sel;

   initial begin
      reset = 1'b1;
      scl_m = 1'b1;
      sda_m = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(1);
      chk("rst_sda_oe", 32'(sda_oe), 32'd0);
      chk("rst_we_rd", {30'd0, reg_we, reg_rd}, 32'd0);
      chk("rst_bus_sel", {30'd0, bus_active, selected}, 32'd0);
      chk("rst_reg_addr", 32'(reg_addr), 32'd0);
      chk("rst_reg_wdata", 32'(reg_wdata), 32'd0);

      // Write 3 data bytes starting at 0x0100
      i2c_start();
      chk("t1_bus_active", 32'(bus_active), 32'd1);
      wr_byte(8'h6C, a[0]);
      chk("t1_selected", 32'(selected), 32'd1);
      wr_byte(8'h01, a[1]);
      wr_byte(8'h00, a[2]);
      wr_byte(8'hAA, a[3]);
      wr_byte(8'hBB, a[4]);
      wr_byte(8'hCC, a[5]);
      i2c_stop();
      tick(4);
      chk("t1_acks", 32'(a), 32'd0);
      chk("t1_bus_sel_after_stop", {30'd0, bus_active, selected}, 32'd0);
      chk("t1_we_count", 32'(we_n), 32'd3);
      chk("t1_we0", {8'd0, we_addr[0], we_data[0]}, 32'h0001_00AA);
      chk("t1_we1", {8'd0, we_addr[1], we_data[1]}, 32'h0001_01BB);
      chk("t1_we2", {8'd0, we_addr[2], we_data[2]}, 32'h0001_02CC);
      chk("t1_final_ptr", 32'(reg_addr), 32'h0103);

      // Combined pointer write / repeated START / read
      i2c_start();
      wr_byte(8'h6C, a[0]);
      wr_byte(8'h30, a[1]);
      wr_byte(8'h0A, a[2]);
      i2c_start();
      wr_byte(8'h6D, a[3]);
      rd_byte(1'b0, d0);
      rd_byte(1'b1, d1);
      chk("t2_oe_after_nack", 32'(sda_oe), 32'd0);
      i2c_stop();
      tick(4);
      chk("t2_acks", 32'(a[3:0]), 32'd0);
      chk("t2_byte0", 32'(d0), 32'h56);
      chk("t2_byte1", 32'(d1), 32'h47);
      chk("t2_rd_count", 32'(rd_n), 32'd2);
      chk("t2_rd_addr0", 32'(rd_addr[0]), 32'h300A);
      chk("t2_rd_addr1", 32'(rd_addr[1]), 32'h300B);
      chk("t2_we_count", 32'(we_n), 32'd3);

      // Wrong address, then correct address after repeated START
      snap_sel = sel_n;
      i2c_start();
      wr_byte(8'h6E, a0);
      tick(4);
      chk("t3_nack", 32'(a0), 32'd1);
      chk("t3_sel_never", 32'(sel_n - snap_sel), 32'd0);
      chk("t3_no_strobes", 32'(we_n + rd_n), 32'd5);
      i2c_start();
      wr_byte(8'h6C, a0);
      chk("t3_ack_after", 32'(a0), 32'd0);
      chk("t3_selected", 32'(selected), 32'd1);
      i2c_stop();

      // Pointer wrap
      i2c_start();
      wr_byte(8'h6C, a[0]);
      wr_byte(8'hFF, a[1]);
      wr_byte(8'hFF, a[2]);
      wr_byte(8'h11, a[3]);
      wr_byte(8'h22, a[4]);
      i2c_stop();
      tick(4);
      chk("t4_acks", 32'(a[4:0]), 32'd0);
      chk("t4_we_count", 32'(we_n), 32'd5);
      chk("t4_we3", {8'd0, we_addr[3], we_data[3]}, 32'h00FF_FF11);
      chk("t4_we4", {8'd0, we_addr[4], we_data[4]}, 32'h0000_0022);
      chk("t4_final_ptr", 32'(reg_addr), 32'h0001);

      // Glitch filter on SDA while SCL is high
      tick(T);
      sda_m = 1'b0;
      tick(2);
      sda_m = 1'b1;
      tick(20);
      chk("t5_glitch_ignored", 32'(bus_active), 32'd0);
      sda_m = 1'b0;
      tick(10);
      chk("t5_long_start", 32'(bus_active), 32'd1);
      sda_m = 1'b1;
      tick(20);
      chk("t5_stop", 32'(bus_active), 32'd0);

      // Reset while the target drives a 0 data bit
      i2c_start();
      wr_byte(8'h6C, a[0]);
      wr_byte(8'h30, a[1]);
      wr_byte(8'h0A, a[2]);
      i2c_start();
      wr_byte(8'h6D, a[3]);
      tick(4);
      chk("t6_acks", 32'(a[3:0]), 32'd0);
      chk("t6_oe_driving0", 32'(sda_oe), 32'd1);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      chk("t6_oe_after_reset", 32'(sda_oe), 32'd0);
      chk("t6_bus_after_reset", 32'(bus_active), 32'd0);
      chk("t6_ptr_after_reset", 32'(reg_addr), 32'd0);
      tick(1);
      snap_oe = oe_hi_n;
      snap_we = we_n;
      snap_rd = rd_n;
      rd_byte(1'b1, d0);
      tick(2);
      chk("t6_ignored_oe", 32'(oe_hi_n - snap_oe), 32'd0);
      chk("t6_ignored_strobes", 32'((we_n - snap_we) + (rd_n - snap_rd)), 32'd0);
      i2c_stop();
      i2c_start();
      wr_byte(8'h6C, a0);
      chk("t6_ack_after_reset", 32'(a0), 32'd0);
      i2c_stop();
      tick(4);

      chk("oe_stable_while_scl_high", 32'(oe_viol), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
